// File: rtl/snax_reqrsp_pkg.sv
// Shared reqrsp types: AMO opcodes, size encoding, and the responder's FSM state,
// registered request and LR/SC reservation.
package snax_reqrsp_pkg;

  localparam int unsigned AddrWidth     = 48;
  localparam int unsigned DataWidth     = 64;
  localparam int unsigned StrbWidth     = DataWidth / 8;
  localparam int unsigned WordAddrWidth = AddrWidth - 3;

  typedef enum logic [3:0] {
    AMONone = 4'h0,
    AMOSwap = 4'h1,
    AMOAdd  = 4'h2,
    AMOAnd  = 4'h3,
    AMOOr   = 4'h4,
    AMOXor  = 4'h5,
    AMOMax  = 4'h6,
    AMOMaxu = 4'h7,
    AMOMin  = 4'h8,
    AMOMinu = 4'h9,
    AMOLR   = 4'hA,
    AMOSC   = 4'hB
  } amo_op_e;

  typedef logic [2:0] size_t;

  typedef enum logic [2:0] {
    StIdle,
    StAccess,
    StCapture,
    StWrite,
    StResp
  } rsp_state_e;

  typedef struct packed {
    logic                     valid;
    logic [WordAddrWidth-1:0] word;
  } resv_t;

  typedef struct packed {
    logic [WordAddrWidth-1:0] word;
    logic                     lane;
    logic                     write;
    logic [DataWidth-1:0]     data;
    logic [StrbWidth-1:0]     strb;
    amo_op_e                  amo;
    size_t                    size;
  } req_t;

  // Byte enables of an atomic operand: full word, or the 32-bit lane picked by addr[2].
  function automatic logic [StrbWidth-1:0] lane_be(size_t size, logic lane);
    if (size == 3'd3) return 8'hFF;
    return lane ? 8'hF0 : 8'h0F;
  endfunction

endpackage

// File: rtl/snax_amo_alu.sv
// Combinational AMO datapath: combines the old SRAM word with the operand on 32 or 64 bits
// and returns the lane-replicated new word plus its byte enables.
module snax_amo_alu
  import snax_reqrsp_pkg::*;
(
  input  amo_op_e     amo_i,
  input  size_t       size_i,
  input  logic        lane_i,
  input  logic [63:0] old_i,
  input  logic [63:0] operand_i,
  output logic [63:0] wdata_o,
  output logic [7:0]  be_o
);

  logic        w_is_word;
  logic        w_is_signed;
  logic [31:0] w_a32;
  logic [31:0] w_b32;
  logic [63:0] w_a;
  logic [63:0] w_b;
  logic [63:0] w_res;

  assign w_is_word   = (size_i == 3'd3);
  assign w_is_signed = (amo_i == AMOMax) || (amo_i == AMOMin);
  assign w_a32       = lane_i ? old_i[63:32] : old_i[31:0];
  assign w_b32       = lane_i ? operand_i[63:32] : operand_i[31:0];

  // 32-bit operands are extended to 64 bits so one comparator serves both widths.
  always_comb begin
    w_a = old_i;
    w_b = operand_i;
    if (!w_is_word) begin
      w_a = w_is_signed ? {{32{w_a32[31]}}, w_a32} : {32'd0, w_a32};
      w_b = w_is_signed ? {{32{w_b32[31]}}, w_b32} : {32'd0, w_b32};
    end
  end

  always_comb begin
    w_res = w_a;
    unique case (amo_i)
      AMOSwap: w_res = w_b;
      AMOAdd:  w_res = w_a + w_b;
      AMOAnd:  w_res = w_a & w_b;
      AMOOr:   w_res = w_a | w_b;
      AMOXor:  w_res = w_a ^ w_b;
      AMOMax:  w_res = ($signed(w_a) > $signed(w_b)) ? w_a : w_b;
      AMOMaxu: w_res = (w_a > w_b) ? w_a : w_b;
      AMOMin:  w_res = ($signed(w_a) < $signed(w_b)) ? w_a : w_b;
      AMOMinu: w_res = (w_a < w_b) ? w_a : w_b;
      default: w_res = w_a;
    endcase
  end

  assign wdata_o = w_is_word ? w_res : {w_res[31:0], w_res[31:0]};
  assign be_o    = lane_be(size_i, lane_i);

endmodule

// File: rtl/snax_amo_responder.sv
// reqrsp responder: runs loads, stores, AMOs and LR/SC against a 1-cycle-latency SRAM,
// one request in flight, one response per request.
module snax_amo_responder
  import snax_reqrsp_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic                 req_write_i,
  input  logic [63:0]          req_data_i,
  input  logic [7:0]           req_strb_i,
  input  logic [3:0]           req_amo_i,
  input  logic [2:0]           req_size_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  output logic [63:0]          rsp_data_o,
  output logic                 rsp_error_o,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic                 mem_req_o,
  output logic [AddrWidth-4:0] mem_addr_o,
  output logic                 mem_we_o,
  output logic [7:0]           mem_be_o,
  output logic [63:0]          mem_wdata_o,
  input  logic [63:0]          mem_rdata_i
);

  rsp_state_e  r_state, w_state_next;
  req_t        r_req;
  resv_t       r_resv;
  logic [63:0] r_rsp_data;
  logic        r_rsp_err;

  logic        w_req_hs, w_in_atomic, w_misaligned, w_bad_size, w_req_err;
  logic        w_is_amo, w_is_lr, w_is_sc, w_is_store, w_resv_hit;
  logic        w_mem_req, w_mem_we;
  logic [63:0] w_alu_wdata;
  logic [7:0]  w_alu_be;

  assign w_req_hs     = req_valid_i && req_ready_o;
  assign w_in_atomic  = (req_amo_i >= 4'h1) && (req_amo_i <= 4'hB);
  assign w_bad_size   = (req_size_i != 3'd2) && (req_size_i != 3'd3);
  assign w_misaligned = (req_size_i == 3'd2) ? (req_addr_i[1:0] != 2'd0)
                                             : (req_addr_i[2:0] != 3'd0);
  assign w_req_err    = (req_amo_i >= 4'hC) || (w_in_atomic && (w_bad_size || w_misaligned));

  assign w_is_amo   = (r_req.amo >= AMOSwap) && (r_req.amo <= AMOMinu);
  assign w_is_lr    = (r_req.amo == AMOLR);
  assign w_is_sc    = (r_req.amo == AMOSC);
  assign w_is_store = (r_req.amo == AMONone) && r_req.write;
  assign w_resv_hit = r_resv.valid && (r_resv.word == r_req.word);

  snax_amo_alu u_alu (
    .amo_i     (r_req.amo),
    .size_i    (r_req.size),
    .lane_i    (r_req.lane),
    .old_i     (r_rsp_data),
    .operand_i (r_req.data),
    .wdata_o   (w_alu_wdata),
    .be_o      (w_alu_be)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_state <= StIdle;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:    if (w_req_hs) w_state_next = w_req_err ? StResp : StAccess;
      StAccess:  w_state_next = (w_is_store || w_is_sc) ? StResp : StCapture;
      StCapture: w_state_next = w_is_amo ? StWrite : StResp;
      StWrite:   w_state_next = StResp;
      StResp:    if (rsp_ready_i) w_state_next = StIdle;
      default:   w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_req      <= '0;
      r_resv     <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: if (w_req_hs) begin
          r_req.word  <= req_addr_i[AddrWidth-1:3];
          r_req.lane  <= req_addr_i[2];
          r_req.write <= req_write_i;
          r_req.data  <= req_data_i;
          r_req.strb  <= req_strb_i;
          r_req.amo   <= amo_op_e'(req_amo_i);
          r_req.size  <= req_size_i;
          r_rsp_err   <= w_req_err;
          r_rsp_data  <= '0;
        end
        StAccess: begin
          if (w_is_sc) begin
            r_rsp_data   <= w_resv_hit ? 64'd0 : 64'd1;
            r_resv.valid <= 1'b0;
          end else if (w_is_lr) begin
            r_resv <= '{valid: 1'b1, word: r_req.word};
          end else if (w_is_store && w_resv_hit) begin
            r_resv.valid <= 1'b0;
          end
        end
        StCapture: r_rsp_data <= mem_rdata_i;
        StWrite:   if (w_resv_hit) r_resv.valid <= 1'b0;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_mem_req   = 1'b0;
    w_mem_we    = 1'b0;
    mem_be_o    = 8'h00;
    mem_wdata_o = r_req.data;
    unique case (r_state)
      StAccess: begin
        if (w_is_store) begin
          w_mem_req = 1'b1;
          w_mem_we  = 1'b1;
          mem_be_o  = r_req.strb;
        end else if (w_is_sc) begin
          w_mem_req = w_resv_hit;
          w_mem_we  = w_resv_hit;
          mem_be_o  = lane_be(r_req.size, r_req.lane);
        end else begin
          w_mem_req = 1'b1;
          mem_be_o  = 8'hFF;
        end
      end
      StWrite: begin
        w_mem_req   = 1'b1;
        w_mem_we    = 1'b1;
        mem_be_o    = w_alu_be;
        mem_wdata_o = w_alu_wdata;
      end
      default: ;
    endcase
  end

  // Gating with rst_ni keeps a write in flight from reaching the SRAM once reset is seen.
  assign mem_req_o   = w_mem_req && rst_ni;
  assign mem_we_o    = w_mem_we && rst_ni;
  assign mem_addr_o  = r_req.word;
  assign req_ready_o = (r_state == StIdle) && rst_ni;
  assign rsp_valid_o = (r_state == StResp);
  assign rsp_data_o  = r_rsp_data;
  assign rsp_error_o = r_rsp_err;

endmodule

// File: doc/snax_amo_responder.md
# snax_amo_responder

Responder end of the SNAX reqrsp protocol: accepts single-beat reqrsp requests (load, store, AMO, LR/SC), executes them against a single-port SRAM with 1-cycle read latency, and returns one response per request. Atomics are performed as read-modify-write on the SRAM. A single LR/SC reservation is maintained. Sits between a core/accelerator reqrsp initiator and a local TCDM bank.

## Interface
- AddrWidth, 48, byte address width
- DataWidth, 64, bus/SRAM word width; fixed at 64 (8 byte lanes)
- clk_i  in  1  clock
- rst_ni  in  1  reset: synchronous, active-low
- req_addr_i  in  AddrWidth  byte address
- req_write_i  in  1  1 = store (ignored when req_amo_i != AMONone)
- req_data_i  in  64  store/AMO operand, lane-aligned
- req_strb_i  in  8  byte strobes for plain stores
- req_amo_i  in  4  amo_op_e
- req_size_i  in  3  size_t (log2 bytes)
- req_valid_i / req_ready_o  in/out  1  request handshake
- rsp_data_o  out  64  read data / old value / SC result
- rsp_error_o  out  1  request rejected
- rsp_valid_o / rsp_ready_i  out/in  1  response handshake
- mem_req_o  out  1  SRAM access strobe (always granted)
- mem_addr_o  out  AddrWidth-3  word address (req_addr_i[AddrWidth-1:3])
- mem_we_o  out  1  write enable
- mem_be_o  out  8  byte enables
- mem_wdata_o  out  64  write data
- mem_rdata_i  in  64  read data, valid cycle after read strobe

## Operation
- FSM states: IDLE, ACCESS, CAPTURE, WRITE, RESP. Request registered on handshake.
- req_ready_o = (state == IDLE) && rst_ni. Only one request in flight.
- Error check at acceptance: amo code 0xC–0xF, or atomic (AMOSwap..AMOSC) with size not 2/3, or atomic address not aligned to 2^size → IDLE→RESP, rsp_error_o=1, rsp_data_o=0, no SRAM access, reservation untouched.
- Plain load: ACCESS (read) → CAPTURE (latch mem_rdata_i) → RESP; rsp_data_o = full word.
- Plain store: ACCESS (write, mem_be_o = req_strb_i, wdata = req_data_i) → RESP; rsp_data_o = 0.
- AMO (Swap..Minu): ACCESS (read) → CAPTURE → WRITE (write result) → RESP; rsp_data_o = full old word.
- Operand width W = 32 (size 2, lane = addr[2], be 0x0F/0xF0) or 64 (size 3, be 0xFF). Add wraps mod 2^W; Max/Min signed on W bits; Maxu/Minu unsigned; Swap writes operand.
- LR: as load; sets reservation {valid, addr[AddrWidth-1:3]}.
- SC: ACCESS: if reservation valid and word address matches → write (lane be as AMO), rsp_data_o=0; else no write, rsp_data_o=1. → RESP. Reservation cleared in either case.
- Plain store or AMO to the reserved word address clears the reservation; accesses to other words do not.
- RESP: rsp_valid_o=1, outputs stable until rsp_ready_i; on handshake → IDLE.

## Timing
- Handshake cycle 0. Store/SC/error response valid cycle 2 (error: cycle 1); load/LR cycle 3; AMO cycle 4 (earliest, rsp_ready_i=1).
- Min. issue interval = latency + 1 (IDLE cycle after RESP).
- mem_req_o high exactly one cycle per SRAM access; 0 in IDLE, CAPTURE, RESP.
- Reset values: state IDLE, rsp_valid_o=0, rsp_error_o=0, rsp_data_o=0, mem_req_o=0, mem_we_o=0, reservation invalid; req_ready_o=0 while rst_ni=0.
- Reset mid-operation: request dropped, no response, no further SRAM write issued from the next cycle.
- rsp_ready_i low: stay in RESP indefinitely, no state or output change.

## Structure
- Reuse snax_reqrsp_pkg (amo_op_e, size_t); add responder state enum and a reservation struct there.
- Combinational sub-module snax_amo_alu: (amo, size, lane, old word, operand) → new word + byte enables.

## Test plan
- Store 0x1122334455667788 strb 0xFF @0x100, then load @0x100 → rsp_data 0x1122334455667788 at cycle 3, error 0.
- AMOAdd size 2 @0x104, mem word 0xFFFFFFFF_00000010, operand 0x00000001_00000000 → rsp old word; mem becomes 0x00000000_00000010 (wrap), be 0xF0.
- AMOMax size 3 @0x108, old 0x8000000000000000, operand 1 → mem 1; AMOMaxu same inputs → mem unchanged value 0x8000000000000000.
- LR @0x200, SC @0x200 → rsp 0, write issued; second SC @0x200 → rsp 1, no mem_req_o.
- LR @0x200, store @0x200, SC @0x200 → rsp 1. AMO size 2 @0x102 → rsp_error 1 at cycle 1, no SRAM access.
- Hold rsp_ready_i low 5 cycles during AMO response → rsp stable, req_ready_o 0; reset asserted in WRITE → no write, rsp_valid_o 0.
